// File: rtl/top_pkg.sv
// Shared types and constants for the 8N1 loopback UART: FSM state enums,
// data width and default baud divider.
package top_pkg;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver with mid-bit sampling, false-start rejection and framing-error
// discard. rx_out only changes on a frame whose stop bit reads 1.
module uart_rx
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              serial,
    output logic [DATA_W-1:0] rx_out
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_out  <= '0;
        end else if (!rx_en) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!serial) state <= RX_START;
                end
                RX_START: begin
                    // Half a bit in: a high line means the low was a glitch.
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= serial ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        shreg   <= {serial, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (serial) rx_out <= shreg;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter. While tx_en is held, frames run back-to-back, and data_in is
// latched on the edge that starts each frame.
module uart_tx
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              serial,
    output logic              done
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              bit_end;

    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == TX_IDLE) cnt <= '0;
            else                  cnt <= bit_end ? '0 : cnt + 1'b1;

            case (state)
                TX_IDLE: begin
                    if (tx_en) begin
                        state <= TX_START;
                        shreg <= data_in;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    // Chain straight into the next start bit so streaming has no idle gap.
                    if (bit_end) begin
                        if (tx_en) begin
                            state <= TX_START;
                            shreg <= data_in;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        serial = 1'b1;
        case (state)
            TX_START: serial = 1'b0;
            TX_DATA:  serial = shreg[0];
            default:  serial = 1'b1;
        endcase
    end

    assign done = (state == TX_STOP) && bit_end;

endmodule

// File: rtl/top.sv
// Loopback UART: transmitter output drives the receiver input internally.
module top
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              fsm_clk,
    output logic [DATA_W-1:0] rx_out
);

    logic serial;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_en   (tx_en),
        .data_in (data_in),
        .serial  (serial),
        .done    (fsm_clk)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_en  (rx_en),
        .serial (serial),
        .rx_out (rx_out)
    );

endmodule

// File: tb/tb_top.sv
// Directed + randomized bench for the loopback UART; the line and rx_out are
// checked against frame bits and byte expectations derived from 8N1 rules.
module tb_top;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       rx_en = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       fsm_clk;
    logic [7:0] rx_out;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_rx = 8'h00;

    top #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_en   (tx_en),
        .rx_en   (rx_en),
        .data_in (data_in),
        .fsm_clk (fsm_clk),
        .rx_out  (rx_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit s of the 10-bit frame: start(0), data LSB first, stop(1).
    function automatic logic frame_bit(input logic [7:0] b, input int s);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[s];
    endfunction

    // Called with tx_en=1 and data_in=b set before the start edge.
    task automatic run_frame(input logic [7:0] b, input bit more, input logic [7:0] nxt,
                             input bit bad_stop, input string tag);
        int pulses;
        int where;
        pulses = 0;
        where  = -1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (fsm_clk) begin
                pulses++;
                where = k;
            end
            if ((k % CPB) == CPB / 2 && !(bad_stop && (k / CPB) == 9))
                chk($sformatf("%s line bit%0d", tag, k / CPB), dut.serial, frame_bit(b, k / CPB));
            if (k == FRAME / 2) data_in = 8'($urandom);
            if (bad_stop && k == FRAME - CPB - 1) force dut.serial = 1'b0;
            if (k == FRAME - 3) chk($sformatf("%s rx_early", tag), rx_out, exp_rx);
            if (k == FRAME - 1) begin
                if (bad_stop) release dut.serial;
                if (rx_en && !bad_stop) exp_rx = b;
                chk($sformatf("%s rx_out", tag), rx_out, exp_rx);
                if (more) data_in = nxt;
                else      tx_en = 1'b0;
            end
        end
        chk($sformatf("%s pulses", tag), pulses, 1);
        chk($sformatf("%s pulse_pos", tag), where, FRAME - 1);
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s idle", tag), {dut.serial, fsm_clk}, 2'b10);
        end
    endtask

    initial begin
        logic [7:0] str [5];
        logic [7:0] rnd [8];
        int         pulses;

        str = '{8'h54, 8'h61, 8'h72, 8'h74, 8'h7A};
        for (int i = 0; i < 8; i++) rnd[i] = 8'($urandom);

        // Reset dominates an asserted tx_en.
        rst_n = 1'b0;
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset fsm_clk", fsm_clk, 1'b0);
        chk("reset rx_out", rx_out, 8'h00);
        chk("reset line", dut.serial, 1'b1);

        // First frame right out of reset.
        rst_n   = 1'b1;
        data_in = 8'h54;
        tx_en   = 1'b1;
        run_frame(8'h54, 1'b0, 8'h00, 1'b0, "single");
        idle_check(12, "after_single");

        // Back-to-back stream, tx_en dropped after the fifth byte.
        data_in = str[0];
        tx_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] nxt;
            nxt = 8'h00;
            if (i < 4) nxt = str[i + 1];
            run_frame(str[i], i < 4, nxt, 1'b0, $sformatf("stream%0d", i));
        end
        idle_check(20, "after_stream");
        chk("stream final", rx_out, 8'h7A);

        // Randomized back-to-back bytes.
        data_in = rnd[0];
        tx_en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] nxt;
            nxt = 8'h00;
            if (i < 7) nxt = rnd[i + 1];
            run_frame(rnd[i], i < 7, nxt, 1'b0, $sformatf("rand%0d", i));
        end
        idle_check(8, "after_rand");

        // Receiver disabled, then enabled.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        rx_en  = 1'b0;
        exp_rx = 8'h00;
        chk("rst2 rx_out", rx_out, 8'h00);
        data_in = 8'hA5;
        tx_en   = 1'b1;
        run_frame(8'hA5, 1'b0, 8'h00, 1'b0, "rx_off");
        idle_check(4, "rx_off");
        rx_en   = 1'b1;
        data_in = 8'h3C;
        tx_en   = 1'b1;
        run_frame(8'h3C, 1'b0, 8'h00, 1'b0, "rx_on");
        idle_check(4, "rx_on");

        // Reset in the middle of data bit 4.
        pulses  = 0;
        data_in = 8'h99;
        tx_en   = 1'b1;
        for (int k = 0; k < 5 * CPB + 1; k++) begin
            @(negedge clk);
            if (fsm_clk) pulses++;
        end
        rst_n = 1'b0;
        tx_en = 1'b0;
        repeat (2) @(negedge clk);
        exp_rx = 8'h00;
        chk("midrst rx_out", rx_out, 8'h00);
        chk("midrst line", dut.serial, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < FRAME + 5; k++) begin
            @(negedge clk);
            if (fsm_clk) pulses++;
        end
        chk("midrst pulses", pulses, 0);
        chk("midrst rx_hold", rx_out, 8'h00);
        data_in = 8'hC3;
        tx_en   = 1'b1;
        run_frame(8'hC3, 1'b0, 8'h00, 1'b0, "post_rst");
        idle_check(4, "post_rst");

        // Stop bit forced low: byte must be discarded.
        data_in = 8'h5A;
        tx_en   = 1'b1;
        run_frame(8'h5A, 1'b0, 8'h00, 1'b1, "framing");
        idle_check(8, "framing");
        chk("framing rx_hold", rx_out, 8'hC3);

        // One-cycle low glitch on an idle line.
        @(negedge clk);
        force dut.serial = 1'b0;
        @(negedge clk);
        release dut.serial;
        idle_check(FRAME + 5, "glitch");
        chk("glitch rx_hold", rx_out, 8'hC3);
        data_in = 8'h96;
        tx_en   = 1'b1;
        run_frame(8'h96, 1'b0, 8'h00, 1'b0, "post_glitch");
        idle_check(4, "post_glitch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
